cmd_frame_tx: RTL
=================

// Module: cmd_frame_tx
// PURPOSE
//  Host-side command frame encoder for the MDM bench command link. Takes one command word
//  {cmd,arg0,arg1} over AXI-Stream and emits the 5-byte frame 0x6E,cmd,arg0,arg1,0x6F as a
//  byte stream into axis_uart_tx_wrapper. Used on a test/controller FPGA driving the bench UART_RX.
// PARAMETERS
//  GAP_CYCLES  16  idle clocks inserted after each frame (CMD_FRAME_TX_GAP_EN only); must be >=1
//  CNT_WIDTH   16  width of frames_sent counter
// PORTS
//  clk          in   1          single clock; all logic on posedge
//  rst_n        in   1          asynchronous, active-low reset
//  clear        in   1          sync abort: drop current frame, return to IDLE
//  i_tdata      in   24         [23:16]=cmd, [15:8]=arg0, [7:0]=arg1
//  i_tvalid     in   1          command word valid
//  i_tready     out  1          command word accepted when i_tvalid&i_tready
//  o_tdata      out  8          frame byte to UART TX
//  o_tvalid     out  1          frame byte valid
//  o_tready     in   1          UART TX ready
//  busy         out  1          high from accept until frame (and gap) complete
//  frames_sent  out  CNT_WIDTH  count of completed frames
// BEHAVIOUR
//  - Reset (rst_n=0, async): state=IDLE, i_tready=0 during reset then 1 in IDLE, o_tvalid=0,
//    o_tdata=0, busy=0, frames_sent=0, holding regs=0.
//  - FSM: IDLE->HEAD->CMD->ARG0->ARG1->TAIL->(GAP)->IDLE. Byte states advance only on
//    o_tvalid&o_tready; IDLE->HEAD on i_tvalid&i_tready.
//  - i_tready = (state==IDLE) & ~clear; combinational from registered state. Accepted word
//    latched into holding regs; later i_tdata changes ignored until next IDLE.
//  - Latency: accept in cycle N -> o_tvalid=1, o_tdata=0x6E in cycle N+1. o_tdata/o_tvalid are
//    registered, held stable until handshake (AXI rule: valid never drops without ready).
//  - Byte order fixed: 0x6E, cmd, arg0, arg1, 0x6F. 16-bit values go arg0=MSB, arg1=LSB.
//  - o_tready=1 throughout: 5 consecutive output beats; min 6 clocks accept-to-accept (no gap).
//  - frames_sent += 1 on TAIL handshake; wraps 2^CNT_WIDTH-1 -> 0. busy = state!=IDLE.
//  - clear: takes precedence over every handshake in that cycle; next cycle IDLE, o_tvalid=0;
//    byte handed over in the clear cycle is not counted; frames_sent unchanged.
//  - Reset mid-frame: frame truncated, no resume. Receiver resyncs on next 0x6E..0x6F window.
//  - cmd/arg values 0x6E/0x6F are sent unescaped; protocol relies on 5-byte alignment.
// CONFIGURATION
//  CMD_FRAME_TX_GAP_EN defined: after TAIL handshake enter GAP, hold busy=1, i_tready=0 for
//  exactly GAP_CYCLES clocks, then IDLE; clear exits GAP immediately.
//  Not defined: TAIL handshake -> IDLE directly; GAP state and GAP_CYCLES logic absent.
// STRUCTURE
//  - Package mdm_cmd_pkg: FRAME_HEAD=8'h6E, FRAME_TAIL=8'h6F, opcodes CMD_RESET=0x00,
//    CMD_ASK_VALUE=0x01 .. CMD_CAPTURE_FIRE=0x0A, FSM state encoding.
//  - Sub-module frame_gap_timer (load/count-down/done), instantiated only under the macro.
// TESTING
//  1 Reset release, o_tready=1, send {0x09,0x05,0x00} -> bytes 6E 09 05 00 6F on 5 consecutive
//    cycles from N+1; frames_sent=1; busy low after last beat.
//  2 o_tready toggling 1010.., send {0x07,0x55,0x55} -> same byte order, o_tdata stable
//    while o_tvalid&~o_tready, no beat duplicated or lost.
//  3 Two words back-to-back, i_tvalid held -> second accepted only in IDLE; 10 beats total;
//    frames_sent=2; gap build: second accept exactly GAP_CYCLES clocks later.
//  4 clear asserted during ARG0 beat -> o_tvalid=0 next cycle, IDLE, frames_sent unchanged;
//    next word {0x0A,0,0} sent as full 6E 0A 00 00 6F.
//  5 rst_n pulsed low mid-CMD -> outputs zero immediately (async); after release new frame clean.
//  6 frames_sent preloaded near wrap (CNT_WIDTH=4 build), 16 frames -> wraps 15->0.

Source files
------------

// File: rtl/mdm_cmd_pkg.sv
// Shared constants for the MDM bench command link: frame delimiters, opcodes,
// the command word layout and the frame encoder state encoding.
package mdm_cmd_pkg;

  localparam logic [7:0] FRAME_HEAD = 8'h6E;
  localparam logic [7:0] FRAME_TAIL = 8'h6F;
  localparam int         FRAME_LEN  = 5;

  localparam logic [7:0] CMD_RESET        = 8'h00;
  localparam logic [7:0] CMD_ASK_VALUE    = 8'h01;
  localparam logic [7:0] CMD_SET_VALUE    = 8'h02;
  localparam logic [7:0] CMD_ARM          = 8'h03;
  localparam logic [7:0] CMD_DISARM       = 8'h04;
  localparam logic [7:0] CMD_SET_MODE     = 8'h05;
  localparam logic [7:0] CMD_SET_THRESH   = 8'h06;
  localparam logic [7:0] CMD_SET_PERIOD   = 8'h07;
  localparam logic [7:0] CMD_READ_STATUS  = 8'h08;
  localparam logic [7:0] CMD_CAPTURE_ARM  = 8'h09;
  localparam logic [7:0] CMD_CAPTURE_FIRE = 8'h0A;

  // 16-bit arguments travel as arg0 = MSB, arg1 = LSB.
  typedef struct packed {
    logic [7:0] cmd;
    logic [7:0] arg0;
    logic [7:0] arg1;
  } cmd_word_t;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HEAD = 3'd1,
    ST_CMD  = 3'd2,
    ST_ARG0 = 3'd3,
    ST_ARG1 = 3'd4,
    ST_TAIL = 3'd5,
    ST_GAP  = 3'd6
  } frame_state_t;

endpackage

// File: rtl/cmd_frame_tx_if.sv
// Command word in / frame byte out stream pair of the command frame encoder.
// master = host side driving commands and draining bytes, slave = encoder.
interface cmd_frame_tx_if;
    logic [23:0] i_tdata;
    logic        i_tvalid;
    logic        i_tready;
    logic [7:0]  o_tdata;
    logic        o_tvalid;
    logic        o_tready;

    modport master (
        output i_tdata, i_tvalid, o_tready,
        input  i_tready, o_tdata, o_tvalid
    );

    modport slave (
        input  i_tdata, i_tvalid, o_tready,
        output i_tready, o_tdata, o_tvalid
    );
endinterface

// File: rtl/cmd_frame_tx_frame_gap_timer.sv
// Post-frame idle timer: load starts a GAP_CYCLES count-down, done marks the last gap clock.
// Only present when CMD_FRAME_TX_GAP_EN is defined.
`ifdef CMD_FRAME_TX_GAP_EN
module frame_gap_timer #(
    parameter int GAP_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic load,
    output logic done
);
    localparam int W = $clog2(GAP_CYCLES + 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clear) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= W'(GAP_CYCLES);
        end else if (cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    // Loaded on the tail beat, so cnt==1 is the GAP_CYCLES-th clock spent in GAP.
    assign done = (cnt == W'(1));
endmodule
`endif

// File: rtl/cmd_frame_tx.sv
// Command frame encoder: one {cmd,arg0,arg1} word in, bytes 6E,cmd,arg0,arg1,6F out.
// Define CMD_FRAME_TX_GAP_EN to insert GAP_CYCLES idle clocks after every frame.
module cmd_frame_tx
    import mdm_cmd_pkg::*;
#(
    parameter int GAP_CYCLES = 16,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clear,
    cmd_frame_tx_if.slave        axis,
    output logic                 busy,
    output logic [CNT_WIDTH-1:0] frames_sent
);

    frame_state_t state;
    cmd_word_t    hold;
    logic [7:0]   o_tdata_q;
    logic         o_tvalid_q;
    logic         in_hs;
    logic         out_hs;

    // rst_n gates ready so the host never sees a handshake while reset is held.
    assign axis.i_tready = (state == ST_IDLE) & ~clear & rst_n;
    assign axis.o_tdata  = o_tdata_q;
    assign axis.o_tvalid = o_tvalid_q;
    assign in_hs         = axis.i_tvalid & axis.i_tready;
    assign out_hs        = o_tvalid_q & axis.o_tready;
    assign busy          = (state != ST_IDLE);

`ifdef CMD_FRAME_TX_GAP_EN
    logic gap_done;

    frame_gap_timer #(.GAP_CYCLES(GAP_CYCLES)) u_gap (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (clear),
        .load  (out_hs & (state == ST_TAIL) & ~clear),
        .done  (gap_done)
    );
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ST_IDLE;
            hold        <= '0;
            o_tdata_q   <= '0;
            o_tvalid_q  <= 1'b0;
            frames_sent <= '0;
        end else if (clear) begin
            // Abort wins over any handshake this cycle; the beat in flight is discarded.
            state      <= ST_IDLE;
            o_tdata_q  <= '0;
            o_tvalid_q <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: if (in_hs) begin
                    hold       <= axis.i_tdata;
                    state      <= ST_HEAD;
                    o_tvalid_q <= 1'b1;
                    o_tdata_q  <= FRAME_HEAD;
                end
                ST_HEAD: if (out_hs) begin
                    state     <= ST_CMD;
                    o_tdata_q <= hold.cmd;
                end
                ST_CMD: if (out_hs) begin
                    state     <= ST_ARG0;
                    o_tdata_q <= hold.arg0;
                end
                ST_ARG0: if (out_hs) begin
                    state     <= ST_ARG1;
                    o_tdata_q <= hold.arg1;
                end
                ST_ARG1: if (out_hs) begin
                    state     <= ST_TAIL;
                    o_tdata_q <= FRAME_TAIL;
                end
                ST_TAIL: if (out_hs) begin
                    frames_sent <= frames_sent + 1'b1;
                    o_tvalid_q  <= 1'b0;
                    o_tdata_q   <= '0;
`ifdef CMD_FRAME_TX_GAP_EN
                    state       <= ST_GAP;
`else
                    state       <= ST_IDLE;
`endif
                end
`ifdef CMD_FRAME_TX_GAP_EN
                ST_GAP: if (gap_done) begin
                    state <= ST_IDLE;
                end
`endif
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule
